// File: rtl/complex_mult_scoreboard.sv
// In-order checking scoreboard for a complex multiplier: predicts {re, im} on every operand
// handshake, queues it, and compares each accepted result against the oldest prediction.
module complex_mult_scoreboard #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter bit SIGNED     = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    sw_rst,
  input  logic                    op_val,
  input  logic                    op_ready,
  input  logic [4*DATA_WIDTH-1:0] op_data,
  input  logic                    res_val,
  input  logic                    res_ready,
  input  logic [4*DATA_WIDTH-1:0] res_data,
  output logic                    chk_pass,
  output logic                    chk_fail,
  output logic                    fail_re,
  output logic                    fail_im,
  output logic [CNT_WIDTH-1:0]    pass_cnt,
  output logic [CNT_WIDTH-1:0]    fail_cnt,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    err_overflow,
  output logic                    err_orphan
);
  localparam int W      = DATA_WIDTH;
  localparam int PW     = 2*DATA_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int PEND_W = AW + 1;

  typedef struct packed {
    logic [PW-1:0] re;
    logic [PW-1:0] im;
  } cplx_t;

  function automatic logic [PW-1:0] ext(input logic [W-1:0] v);
    ext = SIGNED ? {{W{v[W-1]}}, v} : {{W{1'b0}}, v};
  endfunction

  logic          ops_hs, res_hs, pop, push, orphan, full, empty;
  logic [PW-1:0] a, b, c, d;
  cplx_t         pred, head, res;
  cplx_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign ops_hs = op_val & op_ready;
  assign res_hs = res_val & res_ready;
  assign full   = (pending == PEND_W'(DEPTH));
  assign empty  = (pending == '0);
  assign pop    = res_hs & ~empty;
  assign orphan = res_hs & empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push   = ops_hs & (~full | pop);

  assign a = ext(op_data[4*W-1:3*W]);
  assign b = ext(op_data[3*W-1:2*W]);
  assign c = ext(op_data[2*W-1:W]);
  assign d = ext(op_data[W-1:0]);

  // Operands widened to 2W up front so products and sum/difference all wrap mod 2^(2W).
  assign pred.re = a*c - b*d;
  assign pred.im = a*d + b*c;

  assign head = mem[rd_ptr];
  assign res  = cplx_t'(res_data);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pred;
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pending      <= '0;
      chk_pass     <= 1'b0;
      chk_fail     <= 1'b0;
      fail_re      <= 1'b0;
      fail_im      <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      pending <= pending + PEND_W'(1);
      else if (pop && !push) pending <= pending - PEND_W'(1);

      chk_pass <= pop & (head == res);
      chk_fail <= orphan | (pop & (head != res));
      fail_re  <= orphan | (pop & (head.re != res.re));
      fail_im  <= orphan | (pop & (head.im != res.im));

      // Counters follow the registered pulses and stick at all-ones.
      if (chk_pass && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_WIDTH'(1);
      if (chk_fail && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_WIDTH'(1);

      if (ops_hs && full && !pop) err_overflow <= 1'b1;
      if (orphan)                 err_orphan   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_complex_mult_scoreboard.sv
// Bench for complex_mult_scoreboard: unsigned and signed instances share stimulus and are
// checked against a queue-based reference model plus directed constant expectations.
`timescale 1ns/1ps
module tb_complex_mult_scoreboard;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        sw_rst, op_val, op_ready, res_val, res_ready;
  logic [31:0] op_data, res_data;
  logic [1:0]  d_pass, d_fail, d_fre, d_fim, d_ovf, d_orph;
  logic [2:0]  u_pend, s_pend;
  logic [15:0] u_pcnt, u_fcnt;
  logic [2:0]  s_pcnt, s_fcnt;
  int checks = 0;
  int errors = 0;

  // model state: index 0 = unsigned instance, 1 = signed instance (3-bit counters)
  logic [31:0] mq [2][8];
  int          mn [2];
  bit          m_pass [2], m_fail [2], m_fre [2], m_fim [2], m_ovf [2], m_orph [2];
  int          m_pcnt [2], m_fcnt [2];
  int          cmax   [2] = '{65535, 7};

  always #5 clk = ~clk;

  complex_mult_scoreboard #(.DATA_WIDTH(8), .DEPTH(DEPTH), .SIGNED(1'b0), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .sw_rst(sw_rst), .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
    .res_val(res_val), .res_ready(res_ready), .res_data(res_data),
    .chk_pass(d_pass[0]), .chk_fail(d_fail[0]), .fail_re(d_fre[0]), .fail_im(d_fim[0]),
    .pass_cnt(u_pcnt), .fail_cnt(u_fcnt), .pending(u_pend),
    .err_overflow(d_ovf[0]), .err_orphan(d_orph[0]));

  complex_mult_scoreboard #(.DATA_WIDTH(8), .DEPTH(DEPTH), .SIGNED(1'b1), .CNT_WIDTH(3)) s_dut (
    .clk(clk), .sw_rst(sw_rst), .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
    .res_val(res_val), .res_ready(res_ready), .res_data(res_data),
    .chk_pass(d_pass[1]), .chk_fail(d_fail[1]), .fail_re(d_fre[1]), .fail_im(d_fim[1]),
    .pass_cnt(s_pcnt), .fail_cnt(s_fcnt), .pending(s_pend),
    .err_overflow(d_ovf[1]), .err_orphan(d_orph[1]));

  function automatic logic [31:0] predict(int k, logic [31:0] op);
    longint a, b, c, d, re, im;
    if (k == 1) begin
      a = longint'($signed(op[31:24])); b = longint'($signed(op[23:16]));
      c = longint'($signed(op[15:8]));  d = longint'($signed(op[7:0]));
    end else begin
      a = longint'(op[31:24]); b = longint'(op[23:16]);
      c = longint'(op[15:8]);  d = longint'(op[7:0]);
    end
    re = a*c - b*d;
    im = a*d + b*c;
    return {16'(re), 16'(im)};
  endfunction

  function automatic logic [40:0] act_vec(int k);
    logic [15:0] pc, fc;
    logic [2:0]  pd;
    pc = (k == 0) ? u_pcnt : {13'd0, s_pcnt};
    fc = (k == 0) ? u_fcnt : {13'd0, s_fcnt};
    pd = (k == 0) ? u_pend : s_pend;
    return {d_pass[k], d_fail[k], d_fre[k], d_fim[k], d_ovf[k], d_orph[k], pd, pc, fc};
  endfunction

  function automatic logic [40:0] exp_vec(int k);
    return {m_pass[k], m_fail[k], m_fre[k], m_fim[k], m_ovf[k], m_orph[k],
            3'(mn[k]), 16'(m_pcnt[k]), 16'(m_fcnt[k])};
  endfunction

  // Drives one cycle of stimulus, then advances the model at the clock edge.
  task automatic step(input bit rst, input bit ov, input bit orr, input logic [31:0] od,
                      input bit rv, input bit rr, input logic [31:0] rd);
    logic [31:0] h;
    sw_rst = rst; op_val = ov; op_ready = orr; op_data = od;
    res_val = rv; res_ready = rr; res_data = rd;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mn[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_fre[k] = 0; m_fim[k] = 0;
        m_ovf[k] = 0; m_orph[k] = 0; m_pcnt[k] = 0; m_fcnt[k] = 0;
      end else begin
        if (m_pass[k] && m_pcnt[k] < cmax[k]) m_pcnt[k]++;
        if (m_fail[k] && m_fcnt[k] < cmax[k]) m_fcnt[k]++;
        m_pass[k] = 0; m_fail[k] = 0; m_fre[k] = 0; m_fim[k] = 0;
        if (rv && rr) begin
          if (mn[k] == 0) begin
            m_fail[k] = 1; m_fre[k] = 1; m_fim[k] = 1; m_orph[k] = 1;
          end else begin
            h = mq[k][0];
            for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
            mn[k]--;
            m_fre[k]  = (h[31:16] != rd[31:16]);
            m_fim[k]  = (h[15:0]  != rd[15:0]);
            m_fail[k] = m_fre[k] | m_fim[k];
            m_pass[k] = ~m_fail[k];
          end
        end
        if (ov && orr) begin
          if (mn[k] == DEPTH) m_ovf[k] = 1;
          else begin mq[k][mn[k]] = predict(k, od); mn[k]++; end
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_reset();
    step(1, 1, 1, 32'h01020304, 1, 1, 32'h0);
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checks++;
    if ({d_pass, d_fail, d_fre, d_fim, d_ovf, d_orph, u_pend, s_pend, u_pcnt, u_fcnt, s_pcnt, s_fcnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got pass=%b fail=%b ovf=%b orph=%b pend=%0d/%0d pcnt=%0d fcnt=%0d want all 0",
               d_pass, d_fail, d_ovf, d_orph, u_pend, s_pend, u_pcnt, u_fcnt);
    end
  endtask

  task automatic test_basic();
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h03040506, 0, 0, 32'h0);
    checks++;
    if (u_pend !== 3'd1 || s_pend !== 3'd1) begin
      errors++; $display("FAIL basic_pending_push got %0d/%0d want 1", u_pend, s_pend);
    end
    step(0, 0, 0, 32'h0, 1, 1, 32'hFFF70026);
    checks++;
    if (d_pass !== 2'b11 || d_fail !== 2'b00 || u_pend !== 3'd0) begin
      errors++; $display("FAIL basic_pass got pass=%b fail=%b pend=%0d want 11 00 0", d_pass, d_fail, u_pend);
    end
    idle();
    checks++;
    if (d_pass !== 2'b00 || u_pcnt !== 16'd1 || s_pcnt !== 3'd1) begin
      errors++; $display("FAIL basic_count got pass=%b pcnt=%0d/%0d want 00 1 1", d_pass, u_pcnt, s_pcnt);
    end
  endtask

  task automatic test_signed();
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, 1, 32'hFE0304FF, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 1, 32'hFFFB000E);
    checks++;
    if (d_pass !== 2'b10 || d_fail !== 2'b01 || d_fre[0] !== 1'b1 || d_fim[0] !== 1'b1) begin
      errors++; $display("FAIL signed_expect got pass=%b fail=%b fre=%b fim=%b want 10 01 x1 x1",
                         d_pass, d_fail, d_fre, d_fim);
    end
    step(0, 1, 1, 32'hFE0304FF, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 1, 32'h00FBFD0E);
    checks++;
    if (d_pass !== 2'b01 || d_fail !== 2'b10 || d_fre[1] !== 1'b1 || d_fim[1] !== 1'b1) begin
      errors++; $display("FAIL unsigned_expect got pass=%b fail=%b fre=%b fim=%b want 01 10 1x 1x",
                         d_pass, d_fail, d_fre, d_fim);
    end
  endtask

  task automatic test_im_mismatch();
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h03040506, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 1, 32'hFFF70027);
    checks++;
    if (d_fail !== 2'b11 || d_fre !== 2'b00 || d_fim !== 2'b11 || d_pass !== 2'b00) begin
      errors++; $display("FAIL im_mismatch got fail=%b fre=%b fim=%b want 11 00 11", d_fail, d_fre, d_fim);
    end
    idle();
    checks++;
    if (u_fcnt !== 16'd1 || s_fcnt !== 3'd1) begin
      errors++; $display("FAIL im_fail_cnt got %0d/%0d want 1", u_fcnt, s_fcnt);
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, {8'(i+1), 8'd2, 8'd3, 8'(i)}, 0, 0, 32'h0);
    checks++;
    if (u_pend !== 3'd4 || s_pend !== 3'd4 || d_ovf !== 2'b00) begin
      errors++; $display("FAIL fill got pend=%0d/%0d ovf=%b want 4 00", u_pend, s_pend, d_ovf);
    end
    // full with a simultaneous pop: push accepted, no overflow
    step(0, 1, 1, 32'h05020304, 1, 1, mq[0][0]);
    checks++;
    if (d_pass !== 2'b11 || d_ovf !== 2'b00 || u_pend !== 3'd4) begin
      errors++; $display("FAIL full_push_pop got pass=%b ovf=%b pend=%0d want 11 00 4", d_pass, d_ovf, u_pend);
    end
    step(0, 1, 1, 32'h07070707, 0, 0, 32'h0);
    checks++;
    if (d_ovf !== 2'b11 || u_pend !== 3'd4 || s_pend !== 3'd4) begin
      errors++; $display("FAIL overflow got ovf=%b pend=%0d/%0d want 11 4", d_ovf, u_pend, s_pend);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h0, 1, 1, mq[0][0]);
      checks++;
      if (d_pass !== 2'b11 || act_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL drain[%0d] got pass=%b vec=%h want 11 vec=%h", i, d_pass, act_vec(0), exp_vec(0));
      end
    end
    idle();
    checks++;
    if (u_pcnt !== 16'd5 || u_pend !== 3'd0 || d_ovf !== 2'b11) begin
      errors++; $display("FAIL drain_end got pcnt=%0d pend=%0d ovf=%b want 5 0 11", u_pcnt, u_pend, d_ovf);
    end
  endtask

  task automatic test_orphan();
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 1, 32'h12345678);
    checks++;
    if (d_fail !== 2'b11 || d_fre !== 2'b11 || d_fim !== 2'b11 || d_orph !== 2'b11) begin
      errors++; $display("FAIL orphan got fail=%b fre=%b fim=%b orph=%b want 11 11 11 11", d_fail, d_fre, d_fim, d_orph);
    end
    idle();
    checks++;
    if (u_fcnt !== 16'd1 || s_fcnt !== 3'd1 || d_orph !== 2'b11) begin
      errors++; $display("FAIL orphan_cnt got fcnt=%0d/%0d orph=%b want 1 11", u_fcnt, s_fcnt, d_orph);
    end
    step(0, 1, 1, 32'h03040506, 1, 1, 32'h0);
    checks++;
    if (d_fail !== 2'b11 || u_pend !== 3'd1 || s_pend !== 3'd1) begin
      errors++; $display("FAIL orphan_push got fail=%b pend=%0d/%0d want 11 1", d_fail, u_pend, s_pend);
    end
    step(0, 0, 0, 32'h0, 1, 1, 32'hFFF70026);
    checks++;
    if (d_pass !== 2'b11 || u_pend !== 3'd0) begin
      errors++; $display("FAIL orphan_then_pass got pass=%b pend=%0d want 11 0", d_pass, u_pend);
    end
  endtask

  task automatic test_midstream_reset();
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 32'h03040506, 0, 0, 32'h0);
      step(0, 0, 0, 32'h0, 1, 1, 32'hFFF70026);
    end
    step(0, 0, 0, 32'h0, 1, 1, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h01010101, 0, 0, 32'h0);
    checks++;
    if (u_pcnt !== 16'd2 || u_pend !== 3'd3 || d_orph !== 2'b11 || u_fcnt !== 16'd1) begin
      errors++; $display("FAIL pre_reset got pcnt=%0d pend=%0d orph=%b fcnt=%0d want 2 3 11 1",
                         u_pcnt, u_pend, d_orph, u_fcnt);
    end
    step(1, 1, 1, 32'h01010101, 1, 1, 32'h0);
    checks++;
    if ({d_pass, d_fail, d_fre, d_fim, d_ovf, d_orph, u_pend, s_pend, u_pcnt, u_fcnt, s_pcnt, s_fcnt} !== '0) begin
      errors++; $display("FAIL midstream_reset got pass=%b fail=%b orph=%b pend=%0d pcnt=%0d fcnt=%0d want all 0",
                         d_pass, d_fail, d_orph, u_pend, u_pcnt, u_fcnt);
    end
    step(0, 1, 1, 32'h03040506, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 1, 32'hFFF70026);
    checks++;
    if (d_pass !== 2'b11 || d_fail !== 2'b00) begin
      errors++; $display("FAIL post_reset_pass got pass=%b fail=%b want 11 00", d_pass, d_fail);
    end
  endtask

  task automatic test_random();
    logic [31:0] od, rd;
    int r;
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int n = 0; n < 800; n++) begin
      od = $urandom;
      if ($urandom_range(0, 1) == 0) od = od & 32'h3F3F3F3F;
      r = $urandom_range(0, 9);
      if (r < 4 && mn[0] > 0)      rd = mq[0][0];
      else if (r < 8 && mn[1] > 0) rd = mq[1][0];
      else                         rd = $urandom;
      step($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, od,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, rd);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random[%0d] inst%0d got %h want %h", n, k, act_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_im_mismatch();
    test_overflow();
    test_orphan();
    test_midstream_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
